// File: rtl/spi_engine.sv
// SPI master shift engine with register interface, CPOL/CPHA modes and status flags.
// Optional one-entry TX holding buffer: define SPI_ENGINE_TXBUF_EN.
module spi_engine #(
  parameter int WIDTH = 8,
  parameter int NSS   = 2,
  parameter int DIVW  = 4
) (
  input  logic            CLKx4,
  input  logic            nRESET,
  input  logic            WR,
  input  logic            RD,
  input  logic [1:0]      ADDR,
  input  logic [15:0]     WDATA,
  output logic [15:0]     RDATA,
  input  logic            MISO,
  output logic            MOSI,
  output logic            SCK,
  output logic [NSS-1:0]  nSS,
  output logic            IRQ
);

  // state    | meaning
  // ST_IDLE  | waiting for a DATA write; SCK follows CPOL
  // ST_LOAD  | shadow mode/divider, load shifter, present first MOSI bit
  // ST_SHIFT | 2*WIDTH half periods of DIV+1 clocks each
  // ST_DONE  | publish RX, raise DONE, drop BUSY (or chain from buffer)
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] rx_q;
  logic [NSS-1:0]   nss_q;
  logic             cpol_q;
  logic             cpha_q;
  logic             cpol_s_q;
  logic             cpha_s_q;
  logic [DIVW-1:0]  div_q;
  logic [DIVW-1:0]  div_s_q;
  logic [DIVW-1:0]  hcnt_q;
  logic [CW-1:0]    bitcnt_q;
  logic             half_q;
  logic             miso_q;
  logic             sck_q;
  logic             mosi_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  logic             wr_data;
  logic             wr_ctrl;
  logic             wr_div;
  logic             rd_data;
  logic             engaged;
  logic             hexp;
  logic             last_edge;
  logic             ovr_evt;
  logic             cpol_d;
  logic             txfull;
  logic             unused_bits;

  assign wr_data = WR && (ADDR == 2'd0);
  assign wr_ctrl = WR && (ADDR == 2'd1);
  assign wr_div  = WR && (ADDR == 2'd2);
  assign rd_data = RD && (ADDR == 2'd0);
  assign engaged = (state_q != ST_IDLE);
  assign hexp    = (hcnt_q == '0);
  assign cpol_d  = wr_ctrl ? WDATA[4] : cpol_q;

  // Frame ends on the trailing edge after the last sample; in CPHA=1 that
  // trailing edge is itself the last sample.
  assign last_edge = hexp && half_q &&
                     (bitcnt_q == (cpha_s_q ? CW'(1) : CW'(0)));

`ifdef SPI_ENGINE_TXBUF_EN
  logic [WIDTH-1:0] txbuf_q;
  logic             txfull_q;
  logic             buf_store;
  logic             chain_new;

  assign buf_store = wr_data && ((state_q == ST_LOAD) || (state_q == ST_SHIFT)) && !txfull_q;
  assign chain_new = wr_data && (state_q == ST_DONE) && !txfull_q;
  assign ovr_evt   = wr_data && engaged && txfull_q;
  assign txfull    = txfull_q;
`else
  assign ovr_evt   = wr_data && engaged;
  assign txfull    = 1'b0;
`endif

  assign unused_bits = &{1'b0, WDATA};

  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      nss_q     <= '1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      cpol_s_q  <= 1'b0;
      cpha_s_q  <= 1'b0;
      div_q     <= '0;
      div_s_q   <= '0;
      hcnt_q    <= '0;
      bitcnt_q  <= '0;
      half_q    <= 1'b0;
      miso_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPI_ENGINE_TXBUF_EN
      txbuf_q   <= '0;
      txfull_q  <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        nss_q  <= WDATA[NSS-1:0];
        cpol_q <= WDATA[4];
        cpha_q <= WDATA[5];
      end
      if (wr_div) begin
        div_q <= WDATA[DIVW-1:0];
      end

      // A fresh overrun beats a simultaneous clear request.
      if (ovr_evt) begin
        overrun_q <= 1'b1;
      end else if (wr_ctrl && WDATA[6]) begin
        overrun_q <= 1'b0;
      end

      if (state_q == ST_DONE) begin
        done_q <= 1'b1;
      end else if (wr_data || rd_data) begin
        done_q <= 1'b0;
      end

`ifdef SPI_ENGINE_TXBUF_EN
      if (buf_store) begin
        txbuf_q  <= WDATA[WIDTH-1:0];
        txfull_q <= 1'b1;
      end
`endif

      unique case (state_q)
        ST_IDLE: begin
          sck_q <= cpol_d;
          if (wr_data) begin
            tx_q    <= WDATA[WIDTH-1:0];
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cpol_s_q <= cpol_q;
          cpha_s_q <= cpha_q;
          div_s_q  <= div_q;
          hcnt_q   <= div_q;
          busy_q   <= 1'b1;
          shift_q  <= tx_q;
          bitcnt_q <= CW'(WIDTH);
          mosi_q   <= tx_q[WIDTH-1];
          sck_q    <= cpol_q;
          half_q   <= 1'b0;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (hexp) begin
            hcnt_q <= div_s_q;
            sck_q  <= ~sck_q;
            half_q <= ~half_q;
            if (!half_q) begin
              if (!cpha_s_q) begin
                miso_q   <= MISO;
                bitcnt_q <= bitcnt_q - CW'(1);
              end else begin
                mosi_q <= shift_q[WIDTH-1];
              end
            end else begin
              if (!cpha_s_q) begin
                shift_q <= {shift_q[WIDTH-2:0], miso_q};
                mosi_q  <= shift_q[WIDTH-2];
              end else begin
                shift_q  <= {shift_q[WIDTH-2:0], MISO};
                bitcnt_q <= bitcnt_q - CW'(1);
              end
              if (last_edge) begin
                state_q <= ST_DONE;
              end
            end
          end else begin
            hcnt_q <= hcnt_q - DIVW'(1);
          end
        end
        ST_DONE: begin
          rx_q    <= shift_q;
          busy_q  <= 1'b0;
          sck_q   <= cpol_s_q;
          state_q <= ST_IDLE;
`ifdef SPI_ENGINE_TXBUF_EN
          // Chain straight into the next frame; nSS is left alone.
          if (txfull_q) begin
            tx_q     <= txbuf_q;
            txfull_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_LOAD;
          end else if (chain_new) begin
            tx_q    <= WDATA[WIDTH-1:0];
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    RDATA = '0;
    case (ADDR)
      2'd0: RDATA[WIDTH-1:0] = rx_q;
      2'd1: begin
        RDATA[NSS-1:0] = nss_q;
        RDATA[4]       = cpol_q;
        RDATA[5]       = cpha_q;
      end
      2'd2: RDATA[DIVW-1:0] = div_q;
      default: RDATA[3:0] = {txfull, overrun_q, done_q, busy_q};
    endcase
  end

  assign SCK  = sck_q;
  assign MOSI = mosi_q;
  assign nSS  = nss_q;
  assign IRQ  = done_q;

endmodule

// File: tb/tb_spi_engine.sv
// Self-checking bench for spi_engine: frame-level timing model plus directed register checks.
module tb_spi_engine;
  localparam int W = 8;

  logic        CLKx4 = 1'b0;
  logic        nRESET = 1'b0;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  logic [1:0]  ADDR = 2'd0;
  logic [15:0] WDATA = 16'h0;
  logic [15:0] RDATA;
  logic        MISO;
  logic        MOSI;
  logic        SCK;
  logic [1:0]  nSS;
  logic        IRQ;

  logic loop_en = 1'b0;
  logic miso_drv = 1'b0;
  assign MISO = loop_en ? MOSI : miso_drv;

  spi_engine #(.WIDTH(W), .NSS(2), .DIVW(4)) dut (
    .CLKx4 (CLKx4),
    .nRESET(nRESET),
    .WR    (WR),
    .RD    (RD),
    .ADDR  (ADDR),
    .WDATA (WDATA),
    .RDATA (RDATA),
    .MISO  (MISO),
    .MOSI  (MOSI),
    .SCK   (SCK),
    .nSS   (nSS),
    .IRQ   (IRQ)
  );

  always #5 CLKx4 = ~CLKx4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge CLKx4) cyc <= cyc + 1;

  // settings the bench has programmed
  logic [1:0] exp_nss = 2'b11;
  logic       ctrl_cpol = 1'b0;
  logic       ctrl_cpha = 1'b0;
  int         cur_div = 0;

  // frame model: k = clocks since the DATA write edge
  bit         m_on = 1'b0;
  int         f_start = 0;
  logic [7:0] m_tx = 8'h0;
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  int         m_div = 0;
  int         mk, mp, mh, mq;
  logic       m_sck;

  // MISO source that changes on each SCK leading edge
  bit         drv_on = 1'b0;
  logic [7:0] drv_src = 8'h0;
  int         drv_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the frame rules: SCK is idle level for the
  // first half period after LOAD and toggles every DIV+1 clocks for 2*W half
  // periods; each MOSI bit must be valid just before its sample edge.
  always begin
    @(posedge CLKx4);
    #1;
    if (m_on) begin
      check("nss", nSS, exp_nss);
      mk = cyc - f_start;
      mp = 2 * W * (m_div + 1);
      if (mk >= 0 && mk <= mp + 2) begin
        if (mk >= 1 && mk <= mp + 1) begin
          mh = (mk - 1) / (m_div + 1);
          m_sck = m_cpol ^ mh[0];
        end else begin
          m_sck = m_cpol;
        end
        check("sck", SCK, m_sck);
        check("irq", IRQ, (mk >= mp + 2));
        if (mk % (m_div + 1) == 0) begin
          mq = mk / (m_div + 1) - 1 - int'(m_cpha);
          if (mq >= 0 && mq % 2 == 0 && mq / 2 < W)
            check("mosi", MOSI, m_tx[W-1-mq/2]);
        end
      end
    end
  end

  always @(SCK) begin
    if (drv_on && (SCK !== m_cpol) && drv_idx < W) begin
      miso_drv = drv_src[W-1-drv_idx];
      drv_idx++;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge CLKx4);
    ADDR = a; WDATA = d; WR = 1'b1;
    @(posedge CLKx4);
    if (a == 2'd1) begin
      exp_nss = d[1:0]; ctrl_cpol = d[4]; ctrl_cpha = d[5];
    end
    if (a == 2'd2) cur_div = int'(d[3:0]);
    #1 WR = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] tx, input bit use_model);
    @(negedge CLKx4);
    m_tx = tx; m_cpol = ctrl_cpol; m_cpha = ctrl_cpha; m_div = cur_div;
    f_start = cyc + 1; drv_idx = 0; m_on = use_model;
    ADDR = 2'd0; WDATA = {8'h00, tx}; WR = 1'b1;
    @(posedge CLKx4);
    #1 WR = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    @(negedge CLKx4);
    ADDR = a;
    #1 v = RDATA;
  endtask

  task automatic rd_strobe(input logic [1:0] a);
    @(negedge CLKx4);
    ADDR = a; RD = 1'b1;
    @(posedge CLKx4);
    #1 RD = 1'b0;
  endtask

  task automatic wait_irq(output int n, input int limit);
    n = 0;
    while (!IRQ && n < limit) begin
      @(posedge CLKx4);
      #1;
      n++;
    end
    if (!IRQ) begin
      total++; bad++;
      $display("FAIL irq_timeout: got IRQ=0 after %0d clocks, expected IRQ=1", n);
    end
  endtask

  logic [15:0] v;
  int n;

  initial begin
    repeat (3) @(posedge CLKx4);
    @(negedge CLKx4) nRESET = 1'b1;

    // reset state
    rd(2'd0, v); check("rst_rx", v, 16'h0000);
    rd(2'd1, v); check("rst_ctrl", v, 16'h0003);
    rd(2'd2, v); check("rst_div", v, 16'h0000);
    rd(2'd3, v); check("rst_status", v, 16'h0000);
    check("rst_nss", nSS, 2'b11);
    check("rst_sck", SCK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_irq", IRQ, 1'b0);

    // mode 0, DIV=1, loopback
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0001);
    loop_en = 1'b1;
    start_frame(8'hA5, 1'b1);
    wait_irq(n, 200);
    check("lat_mode0", n, 34);
    m_on = 1'b0;
    rd(2'd0, v); check("rx_mode0", v, 16'h00A5);
    check("irq_mode0", IRQ, 1'b1);
    rd(2'd3, v); check("status_done", v, 16'h0002);
    rd_strobe(2'd0);
    check("irq_rd_clear", IRQ, 1'b0);

    // mode 3, DIV=0, MISO from 0xC3
    loop_en = 1'b0;
    wr(2'd1, 16'h0032);
    check("sck_idle_cpol1", SCK, 1'b1);
    wr(2'd2, 16'h0000);
    drv_src = 8'hC3;
    drv_on = 1'b1;
    start_frame(8'h3C, 1'b1);
    wait_irq(n, 100);
    check("lat_mode3", n, 18);
    m_on = 1'b0;
    drv_on = 1'b0;
    rd(2'd0, v); check("rx_mode3", v, 16'h00C3);
    check("sck_after_mode3", SCK, 1'b1);

`ifndef SPI_ENGINE_TXBUF_EN
    // DATA write while busy is dropped and flagged
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0001);
    loop_en = 1'b1;
    start_frame(8'h5A, 1'b1);
    repeat (10) @(posedge CLKx4);
    wr(2'd0, 16'h00FF);
    rd(2'd3, v); check("ovr_busy", v, 16'h0005);
    wait_irq(n, 200);
    m_on = 1'b0;
    rd(2'd0, v); check("rx_ovr", v, 16'h005A);
    rd(2'd3, v); check("status_ovr_done", v, 16'h0006);
    wr(2'd1, 16'h0042);
    rd(2'd3, v); check("ovr_cleared", v, 16'h0002);
    wr(2'd3, 16'hFFFF);
    rd(2'd3, v); check("status_ro", v, 16'h0002);
`else
    // buffered back-to-back frames
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0000);
    loop_en = 1'b1;
    start_frame(8'h11, 1'b0);
    wr(2'd0, 16'h0022);
    rd(2'd3, v); check("txfull_set", v, 16'h0009);
    wr(2'd0, 16'h0033);
    rd(2'd3, v); check("ovr_full", v, 16'h000D);
    n = 0;
    rd(2'd3, v);
    while (v[0] && n < 200) begin
      rd(2'd3, v);
      n++;
    end
    check("chain_len", cyc - f_start, 36);
    rd(2'd0, v); check("rx_chain", v, 16'h0022);
    check("irq_chain", IRQ, 1'b1);
    wr(2'd1, 16'h0042);
    rd(2'd3, v); check("ovr_cleared_buf", v, 16'h0002);
`endif

    // reset in the middle of a frame
    wr(2'd1, 16'h0002);
    wr(2'd2, 16'h0001);
    loop_en = 1'b1;
    start_frame(8'h96, 1'b1);
    repeat (16) @(posedge CLKx4);
    m_on = 1'b0;
    #3 nRESET = 1'b0;
    #1;
    check("rst_mid_nss", nSS, 2'b11);
    check("rst_mid_sck", SCK, 1'b0);
    check("rst_mid_irq", IRQ, 1'b0);
    rd(2'd3, v); check("rst_mid_status", v, 16'h0000);
    rd(2'd0, v); check("rst_mid_rx", v, 16'h0000);
    exp_nss = 2'b11; ctrl_cpol = 1'b0; ctrl_cpha = 1'b0; cur_div = 0;
    @(negedge CLKx4) nRESET = 1'b1;

    wr(2'd1, 16'h0001);
    wr(2'd2, 16'h0002);
    start_frame(8'h69, 1'b1);
    wait_irq(n, 200);
    check("lat_after_rst", n, 50);
    m_on = 1'b0;
    rd(2'd0, v); check("rx_after_rst", v, 16'h0069);
    check("nss_after_rst", nSS, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
